// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; signs are re-applied on the final (FIX) edge.
module mul_div_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] DIVZERO_QUOT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MDCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, psign, rsign, divz;
  logic [WIDTH-1:0] acc, q, opb, a_orig;

  logic             go, mt;
  logic             sgn_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign go     = Start && !Flush && (state == IDLE) && !MDCtl[2];
  assign mt     = Start && !Flush && (state == IDLE) && (MDCtl[2:1] == 2'b10);
  assign sgn_op = !MDCtl[0];
  assign a_abs  = (sgn_op && A[WIDTH-1]) ? -A : A;
  assign b_abs  = (sgn_op && B[WIDTH-1]) ? -B : B;

  // Multiply: shift-add, product builds up in {acc, q} as the multiplier shifts out of q.
  assign mul_sum = {1'b0, acc} + {1'b0, (q[0] ? opb : '0)};
  // Divide: restoring, dividend bits shift out of q's top while quotient bits shift in.
  assign rem_sh  = {acc, q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, opb};
  assign sub     = rem_sh[WIDTH-1:0] - opb;

  assign prod     = {acc, q};
  assign prod_fix = psign ? -prod : prod;
  assign quo_fix  = psign ? -q : q;
  assign rem_fix  = rsign ? -acc : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = CALC;
      CALC: if (Flush) state_nxt = IDLE;
            else if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      psign  <= 1'b0;
      rsign  <= 1'b0;
      divz   <= 1'b0;
      acc    <= '0;
      q      <= '0;
      opb    <= '0;
      a_orig <= '0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            cnt    <= '0;
            is_div <= MDCtl[1];
            psign  <= sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            rsign  <= sgn_op && A[WIDTH-1];
            divz   <= MDCtl[1] && (B == '0);
            acc    <= '0;
            q      <= a_abs;
            opb    <= b_abs;
            a_orig <= A;
          end else if (mt) begin
            if (MDCtl[0]) LO <= A;
            else          HI <= A;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= ge ? sub : rem_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!Flush) begin
            Done <= 1'b1;
            if (!is_div) begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end else if (divz) begin
              HI <= a_orig;
              LO <= DIVZERO_QUOT;
            end else begin
              HI <= rem_fix;
              LO <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latency, flush and reset cases.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdctl;
  logic [31:0] a, b;
  logic        flush;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .MDCtl(mdctl), .A(a), .B(b),
    .Flush(flush), .HI(hi), .LO(lo), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] ctl, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; mdctl = ctl; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; mdctl = 3'b110; a = $urandom; b = $urandom;
  endtask

  // Run an op to completion, counting Busy cycles and Done pulses.
  task automatic run_op(input logic [2:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                        output int bcyc, output int dones);
    issue(ctl, av, bv);
    bcyc = 0; dones = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      dones += int'(done);
      @(negedge clk);
    end
    dones += int'(done);
    @(negedge clk);
    dones += int'(done);
  endtask

  int bc, dn;

  initial begin
    rst_n = 1'b0; start = 1'b0; mdctl = 3'b110; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // T1 MULT -3*5
    run_op(3'b000, 32'hFFFFFFFD, 32'd5, bc, dn);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFF1);
    chk("t1_done_pulses", dn, 1);

    // T2 MULTU max*max
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dn);
    chk("t2_busy_cycles", bc, 33);
    chk("t2_hi", hi, 32'hFFFFFFFE);
    chk("t2_lo", lo, 32'h00000001);

    // T3 DIV -7/2, DIVU 100/7
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, bc, dn);
    chk("t3_div_lo", lo, 32'hFFFFFFFD);
    chk("t3_div_hi", hi, 32'hFFFFFFFF);
    run_op(3'b011, 32'd100, 32'd7, bc, dn);
    chk("t3_divu_lo", lo, 32'd14);
    chk("t3_divu_hi", hi, 32'd2);

    // T4 divide by zero still takes full latency; overflow case
    run_op(3'b011, 32'h1234, 32'd0, bc, dn);
    chk("t4_dz_lo", lo, 32'hFFFFFFFF);
    chk("t4_dz_hi", hi, 32'h1234);
    chk("t4_dz_cycles", bc, 33);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, bc, dn);
    chk("t4_ovf_lo", lo, 32'h80000000);
    chk("t4_ovf_hi", hi, 32'h0);

    // Flush in IDLE alone, and Flush together with MTLO: both no effect
    @(negedge clk); flush = 1'b1; start = 1'b1; mdctl = 3'b101; a = 32'h5555;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    chk("flush_start_lo", lo, 32'h80000000);
    chk("flush_start_busy", busy, 0);

    // T5 flush mid-multiply at cycle 10
    issue(3'b000, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_busy_after_flush", busy, 0);
    dn = int'(done);
    @(negedge clk); dn += int'(done);
    @(negedge clk); dn += int'(done);
    chk("t5_no_done", dn, 0);
    chk("t5_hi_kept", hi, 32'h0);
    chk("t5_lo_kept", lo, 32'h80000000);
    issue(3'b100, 32'hCAFE, 32'h0);
    chk("t5_mthi", hi, 32'hCAFE);
    chk("t5_mthi_busy", busy, 0);

    // T6 MTLO while busy is ignored; reset mid-op
    issue(3'b010, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; mdctl = 3'b101; a = 32'h1111;
    @(negedge clk);
    start = 1'b0; mdctl = 3'b110;
    chk("t6_mtlo_ignored", lo, 32'h80000000);
    chk("t6_busy", busy, 1);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hi", hi, 0);
    chk("t6_rst_lo", lo, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd6, 32'd7, bc, dn);
    chk("t6_mul_lo", lo, 32'd42);
    chk("t6_mul_hi", hi, 32'd0);
    chk("t6_done", dn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
